// File: rtl/genius_datapath.sv
// Genius game datapath: settings/player registers, LFSR sequence generator,
// sequence RAM, match/sequence/score counters and a timed LED display driver.
// It executes the strobes issued by the game FSM and returns its status.
module genius_datapath #(
  parameter int          DATA_WIDTH      = 4,
  parameter int          DIFICULTY_WIDTH = 2,
  parameter int          ADDR_WIDTH      = 5,
  parameter int          LED_TICKS       = 8,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       settings_wr,
  input  logic                       player_wr,
  input  logic                       mem_rd,
  input  logic                       mem_wr,
  input  logic                       inc_match_index,
  input  logic                       inc_sequence_index,
  input  logic                       inc_score,
  input  logic                       rst_match,
  input  logic                       rst_sequence,
  input  logic                       rst_score,
  input  logic                       update_score,
  input  logic                       enable_led,
  input  logic                       all_leds,
  input  logic [DATA_WIDTH-1:0]      buttons,
  input  logic [DIFICULTY_WIDTH-1:0] difficulty_in,
  input  logic                       speed_in,
  input  logic                       mode_in,
  output logic [DATA_WIDTH-1:0]      player_input,
  output logic [DIFICULTY_WIDTH-1:0] difficulty,
  output logic                       speed,
  output logic                       mode,
  output logic [DATA_WIDTH-1:0]      sequence_item,
  output logic [ADDR_WIDTH-1:0]      match_index,
  output logic [ADDR_WIDTH-1:0]      sequence_index,
  output logic [ADDR_WIDTH-1:0]      score,
  output logic [DATA_WIDTH-1:0]      leds,
  output logic                       led_busy
);

  localparam int SEL_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int TW    = $clog2(2 * LED_TICKS + 1);

  logic [15:0]           lfsr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [TW-1:0]         timer;
  logic [DATA_WIDTH-1:0] new_item;
  logic [DATA_WIDTH-1:0] cur_item;
  logic [TW-1:0]         disp_len;

  // New sequence item is one-hot, selected by the low LFSR bits.
  assign new_item = DATA_WIDTH'(1) << lfsr[SEL_W-1:0];
  // The display path reads the RAM directly so LEDs light on the strobe edge.
  assign cur_item = mem[match_index];
  assign disp_len = speed ? TW'(LED_TICKS) : TW'(2 * LED_TICKS);

  // Free-running Galois LFSR, x^16+x^14+x^13+x^11.
  always_ff @(posedge clk) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Sequence RAM write port; contents survive reset but reset blocks writes.
  always_ff @(posedge clk) begin
    if (rst_n && mem_wr) mem[sequence_index] <= new_item;
  end

  // Registered RAM read; same-address write in the same cycle returns old data.
  always_ff @(posedge clk) begin
    if (!rst_n)      sequence_item <= '0;
    else if (mem_rd) sequence_item <= mem[match_index];
  end

  // Game settings latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      difficulty <= '0;
      speed      <= 1'b0;
      mode       <= 1'b0;
    end else if (settings_wr) begin
      difficulty <= difficulty_in;
      speed      <= speed_in;
      mode       <= mode_in;
    end
  end

  // Player press capture: only clean one-hot presses; consuming a press clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)                           player_input <= '0;
    else if (inc_match_index)             player_input <= '0;
    else if (player_wr && $onehot(buttons)) player_input <= buttons;
  end

  // Match and sequence index counters, clear beats increment, wrap on overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_index    <= '0;
      sequence_index <= '0;
    end else begin
      if (rst_match)            match_index <= '0;
      else if (inc_match_index) match_index <= match_index + ADDR_WIDTH'(1);
      if (rst_sequence)            sequence_index <= '0;
      else if (inc_sequence_index) sequence_index <= sequence_index + ADDR_WIDTH'(1);
    end
  end

  // Score: clear, then load from sequence length, then saturating increment.
  always_ff @(posedge clk) begin
    if (!rst_n)            score <= '0;
    else if (rst_score)    score <= '0;
    else if (update_score) score <= sequence_index;
    else if (inc_score && score != '1) score <= score + ADDR_WIDTH'(1);
  end

  // LED display timer: flash always restarts, item display only when idle,
  // LEDs drop on the edge after the timer reaches 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      leds     <= '0;
      led_busy <= 1'b0;
      timer    <= '0;
    end else if (all_leds) begin
      leds     <= '1;
      led_busy <= 1'b1;
      timer    <= disp_len;
    end else if (enable_led && !led_busy) begin
      leds     <= cur_item;
      led_busy <= 1'b1;
      timer    <= disp_len;
    end else if (led_busy) begin
      if (timer == TW'(1)) begin
        leds     <= '0;
        led_busy <= 1'b0;
        timer    <= '0;
      end else begin
        timer <= timer - TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_genius_datapath.sv
// Self-checking bench for genius_datapath: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural model of the game datapath.
module tb_genius_datapath;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       settings_wr, player_wr, mem_rd, mem_wr;
  logic       inc_match_index, inc_sequence_index, inc_score;
  logic       rst_match, rst_sequence, rst_score, update_score;
  logic       enable_led, all_leds;
  logic [3:0] buttons;
  logic [1:0] difficulty_in;
  logic       speed_in, mode_in;
  logic [3:0] player_input, sequence_item, leds;
  logic [1:0] difficulty;
  logic       speed, mode, led_busy;
  logic [4:0] match_index, sequence_index, score;

  int checks = 0;
  int errors = 0;

  genius_datapath dut (
    .clk(clk), .rst_n(rst_n),
    .settings_wr(settings_wr), .player_wr(player_wr),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .inc_match_index(inc_match_index), .inc_sequence_index(inc_sequence_index),
    .inc_score(inc_score), .rst_match(rst_match), .rst_sequence(rst_sequence),
    .rst_score(rst_score), .update_score(update_score),
    .enable_led(enable_led), .all_leds(all_leds),
    .buttons(buttons), .difficulty_in(difficulty_in),
    .speed_in(speed_in), .mode_in(mode_in),
    .player_input(player_input), .difficulty(difficulty), .speed(speed),
    .mode(mode), .sequence_item(sequence_item), .match_index(match_index),
    .sequence_index(sequence_index), .score(score), .leds(leds),
    .led_busy(led_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_lfsr;
  logic [3:0]  m_mem [32];
  int m_match, m_seq, m_score, m_diff, m_speed, m_mode;
  int m_player, m_item, m_leds, m_left;
  bit m_valid = 0;

  // Model advances on each edge from pre-edge state, then compares 1 ns later.
  always @(posedge clk) begin
    int n_item, n_leds, n_left, len, n_score;
    if (!rst_n) begin
      m_lfsr = 16'hACE1;
      m_match = 0; m_seq = 0; m_score = 0; m_diff = 0; m_speed = 0; m_mode = 0;
      m_player = 0; m_item = 0; m_leds = 0; m_left = 0;
      m_valid = 1;
    end else if (m_valid) begin
      len = m_speed ? 8 : 16;
      n_item = mem_rd ? int'(m_mem[m_match]) : m_item;
      n_leds = m_leds; n_left = m_left;
      if (all_leds) begin
        n_leds = 15; n_left = len;
      end else if (enable_led && m_left == 0) begin
        n_leds = int'(m_mem[m_match]); n_left = len;
      end else if (m_left > 0) begin
        n_left = m_left - 1;
        if (n_left == 0) n_leds = 0;
      end
      if (mem_wr) m_mem[m_seq] = 4'(1 << m_lfsr[1:0]);
      n_score = m_score;
      if (rst_score) n_score = 0;
      else if (update_score) n_score = m_seq;
      else if (inc_score) n_score = (m_score + 1 > 31) ? 31 : m_score + 1;
      if (rst_match) m_match = 0;
      else if (inc_match_index) m_match = (m_match + 1) % 32;
      if (rst_sequence) m_seq = 0;
      else if (inc_sequence_index) m_seq = (m_seq + 1) % 32;
      if (inc_match_index) m_player = 0;
      else if (player_wr && $countones(buttons) == 1) m_player = int'(buttons);
      if (settings_wr) begin
        m_diff = int'(difficulty_in); m_speed = int'(speed_in); m_mode = int'(mode_in);
      end
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      m_score = n_score; m_item = n_item; m_leds = n_leds; m_left = n_left;
    end
    #1;
    if (m_valid) begin
      chk("player_input", int'(player_input), m_player);
      chk("difficulty", int'(difficulty), m_diff);
      chk("speed", int'(speed), m_speed);
      chk("mode", int'(mode), m_mode);
      chk("sequence_item", int'(sequence_item), m_item);
      chk("match_index", int'(match_index), m_match);
      chk("sequence_index", int'(sequence_index), m_seq);
      chk("score", int'(score), m_score);
      chk("leds", int'(leds), m_leds);
      chk("led_busy", int'(led_busy), int'(m_left != 0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    settings_wr = 0; player_wr = 0; mem_rd = 0; mem_wr = 0;
    inc_match_index = 0; inc_sequence_index = 0; inc_score = 0;
    rst_match = 0; rst_sequence = 0; rst_score = 0; update_score = 0;
    enable_led = 0; all_leds = 0;
  endtask

  // Counts cycles the LEDs stay lit after a start strobe already applied.
  task automatic count_lit(output int n, input int reenable_at);
    n = 1;
    while (leds != 0 && n < 40) begin
      enable_led = (n == reenable_at);
      tick();
      if (leds != 0) n++;
    end
    enable_led = 0;
  endtask

  initial begin
    int n, guard;
    idle();
    buttons = 4'b0001; difficulty_in = 2'b11; speed_in = 1; mode_in = 1;
    // Reset with strobes active: reset must win.
    rst_n = 0; settings_wr = 1; inc_score = 1; all_leds = 1; inc_match_index = 1;
    tick();
    chk("rst_leds", int'(leds), 0);
    chk("rst_busy", int'(led_busy), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_diff", int'(difficulty), 0);
    rst_n = 1; idle();

    // Fill all 32 RAM entries; first write stores 1<<(ACE1[1:0]) = 0010.
    mem_wr = 1; inc_sequence_index = 1;
    repeat (32) tick();
    idle();
    chk("seq_wrap", int'(sequence_index), 0);
    mem_rd = 1; tick(); mem_rd = 0;
    chk("first_item", int'(sequence_item), 4'b0010);

    // Settings and player capture.
    difficulty_in = 2'b10; speed_in = 1; mode_in = 0; settings_wr = 1; tick(); idle();
    chk("diff_set", int'(difficulty), 2);
    chk("speed_set", int'(speed), 1);
    player_wr = 1; buttons = 4'b0110; tick();
    chk("multi_hot", int'(player_input), 0);
    buttons = 4'b0100; tick(); player_wr = 0;
    chk("one_hot", int'(player_input), 4'b0100);
    inc_match_index = 1; tick(); idle();
    chk("press_clear", int'(player_input), 0);
    chk("match_1", int'(match_index), 1);

    // Counters.
    rst_match = 1; rst_sequence = 1; rst_score = 1; tick(); idle();
    inc_sequence_index = 1; repeat (3) tick(); idle();
    chk("seq_3", int'(sequence_index), 3);
    inc_match_index = 1; repeat (32) tick(); idle();
    chk("match_wrap", int'(match_index), 0);
    inc_match_index = 1; tick();
    rst_match = 1; tick(); idle();
    chk("rst_beats_inc", int'(match_index), 0);
    inc_score = 1; repeat (31) tick();
    chk("score_31", int'(score), 31);
    tick(); idle();
    chk("score_sat", int'(score), 31);
    inc_sequence_index = 1; repeat (2) tick(); idle();
    update_score = 1; inc_score = 1; tick(); idle();
    chk("update_score", int'(score), 5);

    // Same-address read and write returns old data (mem[0] = 0010).
    rst_match = 1; rst_sequence = 1; tick(); idle();
    mem_rd = 1; mem_wr = 1; tick(); idle();
    chk("rd_wr_old", int'(sequence_item), 4'b0010);

    // Plant 1000 at index 0: wait for LFSR low bits = 3.
    guard = 0;
    while (m_lfsr[1:0] != 2'b11 && guard < 64) begin tick(); guard++; end
    mem_wr = 1; tick(); idle();
    mem_rd = 1; tick(); idle();
    chk("item_1000", int'(sequence_item), 4'b1000);

    // Fast display (8 cycles) with ignored second enable.
    enable_led = 1; tick();
    chk("led_on", int'(leds), 4'b1000);
    chk("led_busy_on", int'(led_busy), 1);
    count_lit(n, 3);
    chk("fast_len", n, 8);

    // Slow display (16 cycles).
    speed_in = 0; settings_wr = 1; tick(); idle();
    enable_led = 1; tick(); enable_led = 0;
    count_lit(n, 0);
    chk("slow_len", n, 16);

    // Flash override mid-display restarts the timer.
    enable_led = 1; tick(); enable_led = 0;
    repeat (3) tick();
    all_leds = 1; tick(); all_leds = 0;
    chk("flash_on", int'(leds), 4'hF);
    count_lit(n, 0);
    chk("flash_len", n, 16);

    // Reset mid-display.
    enable_led = 1; tick(); enable_led = 0; tick();
    rst_n = 0; tick(); rst_n = 1;
    chk("rst_mid_leds", int'(leds), 0);
    chk("rst_mid_busy", int'(led_busy), 0);

    // Randomized phase.
    repeat (3000) begin
      rst_n              = ($urandom_range(0, 199) != 0);
      settings_wr        = ($urandom_range(0, 15) == 0);
      player_wr          = ($urandom_range(0, 3) == 0);
      mem_rd             = ($urandom_range(0, 2) == 0);
      mem_wr             = ($urandom_range(0, 3) == 0);
      inc_match_index    = ($urandom_range(0, 3) == 0);
      inc_sequence_index = ($urandom_range(0, 3) == 0);
      inc_score          = ($urandom_range(0, 2) == 0);
      rst_match          = ($urandom_range(0, 15) == 0);
      rst_sequence       = ($urandom_range(0, 15) == 0);
      rst_score          = ($urandom_range(0, 31) == 0);
      update_score       = ($urandom_range(0, 15) == 0);
      enable_led         = ($urandom_range(0, 5) == 0);
      all_leds           = ($urandom_range(0, 39) == 0);
      buttons            = 4'($urandom_range(0, 15));
      difficulty_in      = 2'($urandom_range(0, 3));
      speed_in           = 1'($urandom_range(0, 1));
      mode_in            = 1'($urandom_range(0, 1));
      tick();
    end
    rst_n = 1; idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/genius_datapath.md
Name: genius_datapath

Overview:
Responder side of the Genius game control interface: executes the strobes issued by the game FSM and returns the status it consumes. It contains the settings and player registers, the LFSR-based sequence generator and sequence RAM, the match/sequence index counters, the score register, and a timed LED display driver. It sits between the FSM and the board I/O (buttons, switches, LEDs).

Parameters:
DATA_WIDTH, 4, LED/button count; sequence items are one-hot of this width
DIFICULTY_WIDTH, 2, difficulty field width
ADDR_WIDTH, 5, sequence RAM address and index counter width (32 entries)
LED_TICKS, 8, display cycles per item at fast speed; slow speed is 2*LED_TICKS
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
settings_wr  in  1  capture difficulty_in/speed_in/mode_in
player_wr  in  1  enable capture of player button
mem_rd  in  1  read RAM at match_index
mem_wr  in  1  write new random item at sequence_index
inc_match_index  in  1  increment match_index
inc_sequence_index  in  1  increment sequence_index
inc_score  in  1  increment score
rst_match  in  1  clear match_index
rst_sequence  in  1  clear sequence_index
rst_score  in  1  clear score
update_score  in  1  load score from sequence_index
enable_led  in  1  start display of current item
all_leds  in  1  start all-LEDs flash
buttons  in  DATA_WIDTH  raw player buttons
difficulty_in  in  DIFICULTY_WIDTH  difficulty switches
speed_in  in  1  speed switch (1 = fast)
mode_in  in  1  mode switch
player_input  out  DATA_WIDTH  captured player press
difficulty  out  DIFICULTY_WIDTH  latched difficulty
speed  out  1  latched speed
mode  out  1  latched mode
sequence_item  out  DATA_WIDTH  registered RAM read data
match_index  out  ADDR_WIDTH  match counter
sequence_index  out  ADDR_WIDTH  sequence length counter
score  out  ADDR_WIDTH  score
leds  out  DATA_WIDTH  LED drive
led_busy  out  1  display timer running

Behaviour:
- All state updates on posedge clk; reset when rst_n=0 at an edge, overrides every strobe.
- Reset values: all outputs 0; LFSR = LFSR_SEED; timer 0. RAM contents not reset.
- Settings: settings_wr=1 -> difficulty/speed/mode <= inputs next cycle; else hold.
- Player: player_wr=1 and buttons exactly one-hot -> player_input <= buttons. Zero or multi-hot press ignored (hold). inc_match_index=1 (press consumed) clears player_input; clear wins over a same-cycle capture.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11 (mask 16'hB400), advances every cycle.
- RAM write: mem_wr=1 -> mem[sequence_index] <= 1 << lfsr[1:0] (current LFSR value; lfsr[log2(DATA_WIDTH)-1:0] in general).
- RAM read: mem_rd=1 -> sequence_item <= mem[match_index], 1-cycle latency; else holds. Same-address read and write in one cycle returns old data.
- match_index: rst_match > inc_match_index; increment wraps modulo 2^ADDR_WIDTH. Same rule for sequence_index with rst_sequence/inc_sequence_index.
- score: priority rst_score > update_score (score <= sequence_index) > inc_score (+1, saturates at all ones).
- LED driver, timer T:
  - all_leds=1 -> leds <= all ones, T <= display length, led_busy <= 1; applies even when busy (restarts flash).
  - else enable_led=1 and led_busy=0 -> leds <= mem[match_index] (direct read, same cycle as the strobe), T <= display length, led_busy <= 1.
  - enable_led while busy is ignored.
  - Display length = LED_TICKS if speed=1, else 2*LED_TICKS.
  - While busy, T decrements each cycle; when T reaches 1, the next edge sets leds <= 0 and led_busy <= 0. LEDs are therefore lit exactly display-length cycles.
- Simultaneous strobes on different resources are independent, with no ordering between them.

Test Plan:
- Reset: drive strobes, rst_n=0 for 1 edge -> all outputs 0. LFSR = 16'hACE1; first mem_wr at index 0 stores 4'b0010 (lfsr[1:0]=01).
- Settings/player: difficulty_in=2'b10, speed_in=1, settings_wr pulse -> difficulty=2, speed=1 next cycle. player_wr with buttons=4'b0110 -> player_input stays 0. buttons=4'b0100 -> 4'b0100. inc_match_index -> 0.
- RAM/index: 3x (mem_wr + inc_sequence_index) -> sequence_index=3. mem_rd at match_index 0..2 -> sequence_item equals written one-hot values, one cycle late. Same-cycle read/write at one address returns old data.
- Counters: inc_match_index x32 from 0 -> wraps to 0. rst_match with inc same cycle -> 0. inc_score at 31 -> stays 31. update_score with sequence_index=5 and inc_score -> score=5.
- LED timing: speed=1, LED_TICKS=8, enable_led pulse with mem[0]=4'b1000 -> leds=4'b1000 and led_busy=1 for exactly 8 cycles, then 0. Second enable_led at cycle 3 is ignored. With speed=0, lit for 16 cycles.
- Flash override: all_leds mid-display -> leds=4'hF immediately next cycle with the timer restarted. rst_n=0 mid-display -> leds=0 and led_busy=0 at the next edge.
